// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO. Frames are start, WL data bits
// LSB first, optional parity, and STOP_BITS stop bits; frames run back-to-back while words are queued.
module uart_tx_fifo #(
   parameter int WL        = 8,
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     data_vld,
   input  logic [WL-1:0]            tx_word,
   output logic                     data_rdy,
   output logic                     uart_tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int CPB_RAW = CLK_FREQ / BAUD_RATE;
   localparam int CPB     = (CPB_RAW < 4) ? 4 : CPB_RAW;
   localparam int BCW     = $clog2(CPB);
   localparam int AW      = $clog2(DEPTH);
   localparam int IW      = $clog2(WL);
   localparam logic [BCW-1:0] CPB_M1 = BCW'(CPB - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   // FIFO storage and bookkeeping
   logic [WL-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;

   // transmitter state
   state_t         state, state_n;
   logic [BCW-1:0] bit_cnt, bit_cnt_n;
   logic [IW-1:0]  bit_idx, bit_idx_n;
   logic           stop_idx, stop_idx_n;
   logic [WL-1:0]  shreg, shreg_n;
   logic           par_bit, par_n;
   logic           tx_r, tx_n;
   logic           busy_r, busy_n;

   logic          push, pop, bypass, load, wr_en, tick, last_stop;
   logic [WL-1:0] load_word;

   assign data_rdy  = (cnt < (AW+1)'(DEPTH));
   assign push      = data_vld & data_rdy;
   assign fifo_cnt  = cnt;
   assign uart_tx   = tx_r;
   assign busy      = busy_r;
   assign tick      = (bit_cnt == '0);
   assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
   // A word arriving on the final stop-bit edge with nothing queued goes straight to the shifter
   assign wr_en     = push & ~bypass;

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      shreg_n    = shreg;
      par_n      = par_bit;
      tx_n       = tx_r;
      busy_n     = busy_r;
      pop        = 1'b0;
      bypass     = 1'b0;
      load       = 1'b0;
      load_word  = mem[rd_ptr];

      if (state != S_IDLE)
         bit_cnt_n = tick ? CPB_M1 : bit_cnt - BCW'(1);

      case (state)
         S_IDLE: begin
            if (cnt != '0) begin
               pop  = 1'b1;
               load = 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               state_n   = S_DATA;
               tx_n      = shreg[0];
               shreg_n   = shreg >> 1;
               bit_idx_n = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_idx == IW'(WL - 1)) begin
                  if (PARITY != 0) begin
                     state_n = S_PAR;
                     tx_n    = par_bit;
                  end else begin
                     state_n    = S_STOP;
                     tx_n       = 1'b1;
                     stop_idx_n = 1'b0;
                  end
               end else begin
                  bit_idx_n = bit_idx + IW'(1);
                  tx_n      = shreg[0];
                  shreg_n   = shreg >> 1;
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               state_n    = S_STOP;
               tx_n       = 1'b1;
               stop_idx_n = 1'b0;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (!last_stop) begin
                  stop_idx_n = 1'b1;
               end else if (cnt != '0) begin
                  pop  = 1'b1;
                  load = 1'b1;
               end else if (push) begin
                  bypass    = 1'b1;
                  load      = 1'b1;
                  load_word = tx_word;
               end else begin
                  state_n = S_IDLE;
                  tx_n    = 1'b1;
                  busy_n  = 1'b0;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (load) begin
         state_n   = S_START;
         tx_n      = 1'b0;
         busy_n    = 1'b1;
         bit_cnt_n = CPB_M1;
         shreg_n   = load_word;
         par_n     = (PARITY == 1) ? ~^load_word : ^load_word;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx_r     <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         shreg    <= shreg_n;
         par_bit  <= par_n;
         tx_r     <= tx_n;
         busy_r   <= busy_n;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
   end

   // storage is not reset; the pointers alone define what is valid
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= tx_word;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parity/stop configurations share one stimulus stream and are
// checked each cycle against a frame-level model, plus literal waveform points.
module tb_uart_tx_fifo;

   localparam int NC  = 4;
   localparam int CPB = 10;
   localparam int PAR [NC] = '{0, 1, 2, 0};
   localparam int STP [NC] = '{1, 1, 1, 2};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          data_vld;
   logic [7:0]    tx_word;
   logic [NC-1:0] tx_w, busy_w, rdy_w;
   logic [2:0]    cnt_w [NC];

   int n_chk = 0;
   int n_pass = 0;
   int ecnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      uart_tx_fifo #(.WL(8), .CLK_FREQ(1000000), .BAUD_RATE(100000),
                     .PARITY(PAR[g]), .STOP_BITS(STP[g]), .DEPTH(4)) dut (
         .CLK(clk), .RST_N(rst_n), .data_vld(data_vld), .tx_word(tx_word),
         .data_rdy(rdy_w[g]), .uart_tx(tx_w[g]), .busy(busy_w[g]), .fifo_cnt(cnt_w[g]));
   end

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s dut%0d t=%0t got %0h want %0h", nm, idx, $time, act, exp);
      else
         n_pass++;
   endtask

   // frame-level model: a queue per configuration and the elapsed time inside the current frame
   logic [7:0] m_q [NC][4];
   int         m_cnt [NC];
   int         m_t   [NC];
   bit         m_act [NC];
   logic [7:0] m_w   [NC];

   function automatic int flen(input int i);
      return (1 + 8 + ((PAR[i] != 0) ? 1 : 0) + STP[i]) * CPB;
   endfunction

   function automatic logic exp_tx(input int i);
      int b, ones;
      if (!m_act[i]) return 1'b1;
      b = m_t[i] / CPB;
      ones = $countones(m_w[i]);
      if (b == 0) return 1'b0;
      if (b <= 8) return m_w[i][b-1];
      if (b == 9 && PAR[i] == 2) return logic'(ones % 2);
      if (b == 9 && PAR[i] == 1) return logic'(1 - ones % 2);
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_t[i] = 0; m_act[i] = 1'b0; m_w[i] = '0;
         end
      end else begin
         for (int i = 0; i < NC; i++) begin
            bit pushed, take_q, byp;
            pushed = data_vld && (m_cnt[i] < 4);
            take_q = 1'b0;
            byp    = 1'b0;
            if (m_act[i]) begin
               m_t[i]++;
               if (m_t[i] == flen(i)) begin
                  if (m_cnt[i] > 0) take_q = 1'b1;
                  else if (pushed) begin
                     byp = 1'b1; m_w[i] = tx_word; m_t[i] = 0;
                  end else m_act[i] = 1'b0;
               end
            end else if (m_cnt[i] > 0) take_q = 1'b1;
            if (take_q) begin
               m_w[i] = m_q[i][0];
               for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
               m_cnt[i]--;
               m_t[i] = 0;
               m_act[i] = 1'b1;
            end
            if (pushed && !byp) begin
               m_q[i][m_cnt[i]] = tx_word;
               m_cnt[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         chk("uart_tx",  i, tx_w[i],   exp_tx(i));
         chk("busy",     i, busy_w[i], m_act[i]);
         chk("fifo_cnt", i, cnt_w[i],  m_cnt[i]);
         chk("data_rdy", i, rdy_w[i],  m_cnt[i] < 4);
      end
   end

   task automatic push(input logic [7:0] w, output int e);
      data_vld = 1'b1;
      tx_word  = w;
      @(posedge clk);
      #1;
      e = ecnt;
      data_vld = 1'b0;
   endtask

   task automatic push_at(input int e_tgt, input logic [7:0] w);
      int e;
      wait (ecnt >= e_tgt - 1);
      #1;
      push(w, e);
      chk("push_edge", 0, e, e_tgt);
   endtask

   task automatic check_at(input int e);
      wait (ecnt >= e);
      #3;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (k < 3000 && !(busy_w == '0 && cnt_w[0] == 0 && cnt_w[1] == 0 &&
                           cnt_w[2] == 0 && cnt_w[3] == 0)) begin
         @(posedge clk);
         #3;
         k++;
      end
      chk("idle_reached", 0, k < 3000, 1);
   endtask

   int n, m;
   int B43 [8] = '{1, 1, 0, 0, 0, 0, 1, 0};
   logic [7:0] BURST [6] = '{8'h43, 8'h45, 8'h52, 8'h50, 8'h41, 8'h42};

   initial begin
      data_vld = 1'b0;
      tx_word  = '0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_tx",  0, tx_w[0],   1);
      chk("rst_busy",0, busy_w[0], 0);
      chk("rst_cnt", 0, cnt_w[0],  0);
      chk("rst_rdy", 0, rdy_w[0],  1);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      // single frame, no parity
      push(8'h43, n);
      check_at(n + 1);
      chk("start_low", 0, tx_w[0], 0);
      chk("start_busy", 0, busy_w[0], 1);
      for (int k = 0; k < 8; k++) begin
         check_at(n + 11 + 10 * k);
         chk("data_bit", 0, tx_w[0], B43[k]);
      end
      check_at(n + 91);
      chk("stop_high", 0, tx_w[0], 1);
      chk("par_odd_43", 1, tx_w[1], 0);
      chk("par_even_43", 2, tx_w[2], 1);
      check_at(n + 100);
      chk("busy_last", 0, busy_w[0], 1);
      check_at(n + 101);
      chk("busy_end", 0, busy_w[0], 0);
      chk("busy_par", 1, busy_w[1], 1);
      check_at(n + 111);
      chk("busy_end_par", 1, busy_w[1], 0);
      chk("busy_end_stop2", 3, busy_w[3], 0);
      wait_idle();

      // parity modes
      push(8'h45, n);
      check_at(n + 91);
      chk("par_odd_45", 1, tx_w[1], 0);
      chk("par_even_45", 2, tx_w[2], 1);
      check_at(n + 110);
      chk("len110_busy", 2, busy_w[2], 1);
      check_at(n + 111);
      chk("len110_done", 2, busy_w[2], 0);
      wait_idle();

      // back-to-back, two stop bits
      push(8'h52, n);
      push(8'h50, m);
      chk("b2b_edge", 0, m, n + 1);
      check_at(n + 110);
      chk("b2b_stop", 3, tx_w[3], 1);
      check_at(n + 111);
      chk("b2b_start", 3, tx_w[3], 0);
      chk("b2b_busy", 3, busy_w[3], 1);
      wait_idle();

      // burst into a 4-deep FIFO
      data_vld = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_word = BURST[i];
         @(posedge clk);
         #1;
         if (i == 4) begin
            chk("burst_full_cnt", 0, cnt_w[0], 4);
            chk("burst_full_rdy", 0, rdy_w[0], 0);
         end
      end
      data_vld = 1'b0;
      chk("burst_drop_cnt", 0, cnt_w[0], 4);
      wait_idle();
      chk("burst_end_busy", 0, busy_w[0], 0);

      // reset mid-frame
      push(8'h31, n);
      push(8'h32, m);
      push(8'h33, m);
      check_at(n + 30);
      chk("pre_rst_cnt", 0, cnt_w[0], 2);
      rst_n = 1'b0;
      #1;
      chk("async_tx", 0, tx_w[0], 1);
      chk("async_busy", 0, busy_w[0], 0);
      chk("async_cnt", 0, cnt_w[0], 0);
      chk("async_rdy", 0, rdy_w[0], 1);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      push(8'h41, n);
      check_at(n + 101);
      chk("post_rst_done", 0, busy_w[0], 0);
      chk("post_rst_cnt", 0, cnt_w[0], 0);
      wait_idle();

      // push on the edge the last stop bit ends
      push(8'h55, n);
      push_at(n + 101, 8'h5a);
      check_at(n + 101);
      chk("gapless_tx", 0, tx_w[0], 0);
      chk("gapless_busy", 0, busy_w[0], 1);
      chk("gapless_cnt", 0, cnt_w[0], 0);
      wait_idle();

      @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
